// File: rtl/ray_tracing_array.sv
// Multi-lane frame sequencer: dispatches raster-order pixel jobs round-robin to ray lanes
// and collects their colours back in the same order onto a single registered pixel stream.
module ray_tracing_array #(
  parameter int NUM_LANES = 4,
  parameter int COORD_W   = 13,
  parameter int COLOR_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COORD_W-1:0]             image_width,
  input  logic [COORD_W-1:0]             image_height,
  output logic                           busy,
  output logic                           frame_done,
  output logic [NUM_LANES-1:0]           lane_req_valid,
  input  logic [NUM_LANES-1:0]           lane_req_ready,
  output logic [COORD_W-1:0]             lane_req_x,
  output logic [COORD_W-1:0]             lane_req_y,
  input  logic [NUM_LANES-1:0]           lane_rsp_valid,
  input  logic [NUM_LANES*3*COLOR_W-1:0] lane_rsp_rgb,
  output logic [NUM_LANES-1:0]           lane_rsp_ready,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [COORD_W-1:0]             pix_x,
  output logic [COORD_W-1:0]             pix_y,
  output logic [COLOR_W-1:0]             pix_r,
  output logic [COLOR_W-1:0]             pix_g,
  output logic [COLOR_W-1:0]             pix_b,
  output logic                           pix_last,
  output logic [1:0]                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a valid, once raised, holds itself and its payload until that transfer.

  localparam int PW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [PW-1:0] LAST_LANE = PW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0]   w_m1, h_m1;
  logic [COORD_W-1:0]   dx, dy, cx, cy;
  logic [PW-1:0]        dp, cp;
  logic [NUM_LANES-1:0] lane_busy, busy_set, busy_clr;
  logic [RGB_W-1:0]     sel_rgb;
  logic                 collecting, out_free, req_fire, acc_fire, pix_fire;
  logic                 dx_last, dy_last, cx_last, cy_last, zero_dim;

  assign collecting = (state == RUN) || (state == DRAIN);
  assign out_free   = !pix_valid || pix_ready;
  assign req_fire   = |(lane_req_valid & lane_req_ready);
  assign acc_fire   = |(lane_rsp_valid & lane_rsp_ready);
  assign pix_fire   = pix_valid && pix_ready;
  assign dx_last    = (dx == w_m1);
  assign dy_last    = (dy == h_m1);
  assign cx_last    = (cx == w_m1);
  assign cy_last    = (cy == h_m1);
  assign zero_dim   = (image_width == '0) || (image_height == '0);
  assign sel_rgb    = lane_rsp_rgb[int'(cp) * RGB_W +: RGB_W];

  assign busy       = collecting;
  assign frame_done = (state == DONE);
  assign lane_req_x = dx;
  assign lane_req_y = dy;
  assign dbg_state  = state;

  // Only the collect pointer's lane may hand back a result, which keeps output in raster order.
  always_comb begin
    lane_req_valid = '0;
    lane_rsp_ready = '0;
    if (state == RUN && !lane_busy[dp]) lane_req_valid[dp] = 1'b1;
    if (collecting && lane_busy[cp] && out_free) lane_rsp_ready[cp] = 1'b1;
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (req_fire) busy_set[dp] = 1'b1;
    if (acc_fire) busy_clr[cp] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_dim ? DONE : RUN;
      RUN:     if (req_fire && dx_last && dy_last) state_nxt = DRAIN;
      DRAIN:   if (pix_fire && pix_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_m1      <= '0;
      h_m1      <= '0;
      dx        <= '0;
      dy        <= '0;
      cx        <= '0;
      cy        <= '0;
      dp        <= '0;
      cp        <= '0;
      lane_busy <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        w_m1 <= image_width - 1'b1;
        h_m1 <= image_height - 1'b1;
        dx   <= '0;
        dy   <= '0;
        cx   <= '0;
        cy   <= '0;
        dp   <= '0;
        cp   <= '0;
      end
      if (req_fire) begin
        dp <= (dp == LAST_LANE) ? '0 : dp + 1'b1;
        if (dx_last) begin
          dx <= '0;
          dy <= dy + 1'b1;
        end else begin
          dx <= dx + 1'b1;
        end
      end
      if (acc_fire) begin
        cp <= (cp == LAST_LANE) ? '0 : cp + 1'b1;
        if (cx_last) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
      // Set and clear never target the same lane: a busy lane is never offered a job.
      lane_busy <= (lane_busy | busy_set) & ~busy_clr;
      if (acc_fire) begin
        pix_valid <= 1'b1;
        pix_x     <= cx;
        pix_y     <= cy;
        pix_r     <= sel_rgb[3*COLOR_W-1:2*COLOR_W];
        pix_g     <= sel_rgb[2*COLOR_W-1:COLOR_W];
        pix_b     <= sel_rgb[COLOR_W-1:0];
        pix_last  <= cx_last && cy_last;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ray_tracing_array.sv
// Bench for ray_tracing_array: three instances (4, 3 and 1 lanes) share one stimulus stream,
// each with its own lane models and raster-order scoreboard.
module tb_ray_tracing_array;

  localparam int COORD_W = 13;
  localparam int COLOR_W = 8;
  localparam int PIX_W   = 2 * COORD_W + 3 * COLOR_W + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [COORD_W-1:0] image_width, image_height;
  logic               pix_ready = 1'b1;
  logic               rand_pready = 1'b0;
  int                 lat [4];
  int                 frame_id = 0;
  int                 n_checks = 0;
  int                 n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) pix_ready = rand_pready ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Colour a lane returns for a pixel; the frame id keeps stale data from matching.
  function automatic logic [3*COLOR_W-1:0] shade(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y, input int fid);
    logic [7:0] xs, ys, fs;
    xs = x[7:0];
    ys = y[7:0];
    fs = 8'(fid);
    return {xs ^ 8'h5a ^ fs, ys * 8'd13 + fs, xs + ys * 8'd7};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NL = (g == 0) ? 4 : (g == 1) ? 3 : 1;

    logic                    busy, frame_done, pix_valid, pix_last;
    logic [NL-1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NL*3*COLOR_W-1:0] rsp_rgb;
    logic [COORD_W-1:0]      req_x, req_y, pix_x, pix_y;
    logic [COLOR_W-1:0]      pix_r, pix_g, pix_b;
    logic [1:0]              dbg_state;

    ray_tracing_array #(.NUM_LANES(NL), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .image_width(image_width), .image_height(image_height),
      .busy(busy), .frame_done(frame_done),
      .lane_req_valid(req_valid), .lane_req_ready(req_ready),
      .lane_req_x(req_x), .lane_req_y(req_y),
      .lane_rsp_valid(rsp_valid), .lane_rsp_rgb(rsp_rgb), .lane_rsp_ready(rsp_ready),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pix_last(pix_last), .dbg_state(dbg_state)
    );

    // scoreboard and frame model: mode 0 idle, 1 frame running, 2 done pulse
    logic [PIX_W-1:0]   exp_q[$];
    int                 mode = 0, njob = 0, nacc = 0, npix = 0, fw = 0, fh = 0;
    bit                 pend, first_req, hold_req, hold_pix;
    bit                 has_job [NL];
    int                 cnt [NL];
    logic [COORD_W-1:0] jx [NL], jy [NL];
    logic [NL-1:0]      prev_req_valid;
    logic [COORD_W-1:0] prev_req_x, prev_req_y;
    logic [PIX_W-1:0]   prev_pix;

    function automatic string tg(input string s);
      return $sformatf("%s_l%0d", s, NL);
    endfunction

    always @(negedge clk) begin
      logic [PIX_W-1:0] e;
      logic [NL-1:0]    exp_rdy;
      int               nxt, c;
      bit               acc;
      // lane models drive
      for (int i = 0; i < NL; i++) begin
        rsp_valid[i] = has_job[i] && cnt[i] == 0;
        rsp_rgb[i*3*COLOR_W +: 3*COLOR_W] = has_job[i] ? shade(jx[i], jy[i], frame_id) : 24'($urandom);
        req_ready[i] = !has_job[i] && ($urandom_range(0, 3) != 0);
      end
      #1;
      if (reset) begin
        check(tg("rst_pix"), {busy, frame_done, pix_valid, pix_last, pix_x, pix_y, pix_r, pix_g, pix_b}, '0);
        check(tg("rst_lane"), {req_valid, rsp_ready, req_x, req_y}, '0);
        exp_q.delete();
        mode = 0; njob = 0; nacc = 0; npix = 0;
        pend = 0; first_req = 0; hold_req = 0; hold_pix = 0;
        for (int i = 0; i < NL; i++) begin
          has_job[i] = 0;
          cnt[i] = 0;
        end
      end else begin
        nxt = (mode == 2) ? 0 : mode;
        check(tg("busy"), busy, mode == 1);
        check(tg("frame_done"), frame_done, mode == 2);
        check(tg("pix_valid"), pix_valid, pend);
        if (first_req) check(tg("first_req"), req_valid[0], 1'b1);
        if (req_valid != 0) check(tg("req_onehot_in_run"), $onehot(req_valid) && mode == 1, 1'b1);
        if (hold_req)
          check(tg("req_hold"), {req_valid, req_x, req_y}, {prev_req_valid, prev_req_x, prev_req_y});
        if (hold_pix)
          check(tg("pix_hold"), {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_last}, {1'b1, prev_pix});
        c = nacc % NL;
        exp_rdy = (has_job[c] && (!pend || pix_ready)) ? (NL'(1) << c) : '0;
        check(tg("rsp_ready"), rsp_ready, exp_rdy);

        hold_req = (req_valid != 0) && ((req_valid & req_ready) == 0);
        prev_req_valid = req_valid;
        prev_req_x = req_x;
        prev_req_y = req_y;
        hold_pix = pend && !pix_ready;
        prev_pix = {pix_x, pix_y, pix_r, pix_g, pix_b, pix_last};
        first_req = 0;

        if (pend && pix_ready) begin
          npix++;
          if (exp_q.size() == 0) begin
            check(tg("pix_extra"), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check(tg("pix"), {pix_x, pix_y, pix_r, pix_g, pix_b, pix_last}, e);
            if (exp_q.size() == 0 && mode == 1) nxt = 2;
          end
        end

        for (int i = 0; i < NL; i++) if (has_job[i] && cnt[i] > 0) cnt[i]--;
        acc = 0;
        for (int i = 0; i < NL; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            has_job[i] = 0;
            nacc++;
            acc = 1;
          end
        end
        for (int i = 0; i < NL; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            check(tg("req_lane"), i, njob % NL);
            check(tg("req_xy"), {req_x, req_y},
                  {COORD_W'(njob % (fw > 0 ? fw : 1)), COORD_W'(njob / (fw > 0 ? fw : 1))});
            has_job[i] = 1;
            jx[i] = req_x;
            jy[i] = req_y;
            cnt[i] = lat[i];
            njob++;
          end
        end
        pend = acc ? 1'b1 : (pend && !pix_ready);

        if (mode == 0 && start) begin
          fw = int'(image_width);
          fh = int'(image_height);
          njob = 0; nacc = 0; npix = 0;
          if (fw == 0 || fh == 0) begin
            nxt = 2;
          end else begin
            nxt = 1;
            first_req = 1;
            for (int y = 0; y < fh; y++)
              for (int x = 0; x < fw; x++)
                exp_q.push_back({COORD_W'(x), COORD_W'(y), shade(COORD_W'(x), COORD_W'(y), frame_id),
                                 (x == fw - 1 && y == fh - 1)});
          end
        end
        mode = nxt;
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input string tag);
    int t = 0;
    repeat (2) @(negedge clk);
    while (!(cfg[0].mode == 0 && cfg[1].mode == 0 && cfg[2].mode == 0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({"timeout_", tag}, t >= 4000, 0);
  endtask

  task automatic pulse_start(input int w, input int h);
    image_width  = COORD_W'(w);
    image_height = COORD_W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input string tag);
    frame_id++;
    pulse_start(w, h);
    wait_idle(tag);
  endtask

  task automatic rand_lat(input int hi);
    for (int i = 0; i < 4; i++) lat[i] = $urandom_range(0, hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    image_width = '0;
    image_height = '0;
    lat = '{3, 3, 3, 3};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_frame(4, 2, "t1");
    lat = '{20, 1, 1, 1};
    run_frame(8, 1, "t2");
    rand_pready = 1'b1;
    rand_lat(5);
    run_frame(3, 3, "t3");
    rand_pready = 1'b0;
    run_frame(0, 5, "t4_zero");
    run_frame(6, 0, "t4_zero_h");

    // a second start mid-frame with other dimensions must be ignored
    lat = '{3, 3, 3, 3};
    frame_id++;
    pulse_start(4, 2);
    repeat (2) @(negedge clk);
    pulse_start(2, 1);
    wait_idle("t4_busy");

    // reset in the middle of a frame, then a clean frame
    rand_lat(4);
    frame_id++;
    pulse_start(4, 4);
    t = 0;
    while (cfg[0].npix < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_t5_pix", t >= 2000, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(4, 4, "t5_after");

    rand_lat(6);
    run_frame(5, 2, "t6");
    rand_pready = 1'b1;
    run_frame(5, 2, "t6_stall");

    for (int k = 0; k < 6; k++) begin
      rand_pready = 1'($urandom_range(0, 1));
      rand_lat(6);
      run_frame($urandom_range(1, 7), $urandom_range(1, 4), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
